// File: rtl/wb_stage.sv
// rtl/wb_stage.sv - writeback stage: ALU/load retirement with load timeout; optional bypass via WB_STAGE_BYPASS_EN
module wb_stage #(
    parameter int LOAD_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ex_valid,
    output logic        ex_ready,
    input  logic [4:0]  ex_rd,
    input  logic [31:0] ex_data,
    input  logic        ex_is_load,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    output logic        write_enable,
    output logic [4:0]  wa3,
    output logic [31:0] wd3,
    output logic        busy,
    output logic        err,
    output logic [15:0] wb_count
`ifdef WB_STAGE_BYPASS_EN
    ,
    input  logic [4:0]  ra1,
    input  logic [4:0]  ra2,
    output logic        byp1_hit,
    output logic        byp2_hit,
    output logic [31:0] byp1_data,
    output logic [31:0] byp2_data
`endif
);

    typedef enum logic {IDLE, WAIT_LOAD} state_t;

    localparam logic [7:0] TIMEOUT_LIM = 8'(LOAD_TIMEOUT);

    state_t      state, state_next;
    logic [7:0]  tcnt, tcnt_next, tcnt_inc;
    logic [4:0]  rd_q, rd_next;
    logic        we_next, err_next;
    logic [4:0]  wa_next;
    logic [31:0] wd_next;

    assign ex_ready = (state == IDLE);
    assign busy     = (state == WAIT_LOAD);
    assign tcnt_inc = tcnt + 8'd1;

    always_comb begin
        state_next = state;
        tcnt_next  = tcnt;
        rd_next    = rd_q;
        we_next    = 1'b0;
        wa_next    = wa3;
        wd_next    = wd3;
        err_next   = err;
        case (state)
            IDLE: begin
                if (ex_valid) begin
                    if (ex_is_load) begin
                        rd_next    = ex_rd;
                        tcnt_next  = 8'd0;
                        state_next = WAIT_LOAD;
                    end else if (ex_rd != 5'd0) begin
                        we_next = 1'b1;
                        wa_next = ex_rd;
                        wd_next = ex_data;
                    end
                end
                // A response in the cycle a load is accepted is not yet owed, so it is not an error.
                if (mem_rvalid && !(ex_valid && ex_is_load)) begin
                    err_next = 1'b1;
                end
            end
            WAIT_LOAD: begin
                if (mem_rvalid) begin
                    state_next = IDLE;
                    if (rd_q != 5'd0) begin
                        we_next = 1'b1;
                        wa_next = rd_q;
                        wd_next = mem_rdata;
                    end
                end else if (tcnt_inc == TIMEOUT_LIM) begin
                    tcnt_next  = tcnt_inc;
                    err_next   = 1'b1;
                    state_next = IDLE;
                end else begin
                    tcnt_next = tcnt_inc;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            tcnt         <= 8'd0;
            rd_q         <= 5'd0;
            write_enable <= 1'b0;
            wa3          <= 5'd0;
            wd3          <= 32'd0;
            err          <= 1'b0;
            wb_count     <= 16'd0;
        end else begin
            state        <= state_next;
            tcnt         <= tcnt_next;
            rd_q         <= rd_next;
            write_enable <= we_next;
            wa3          <= wa_next;
            wd3          <= wd_next;
            err          <= err_next;
            wb_count     <= wb_count + {15'd0, we_next};
        end
    end

`ifdef WB_STAGE_BYPASS_EN
    assign byp1_hit  = write_enable && (wa3 != 5'd0) && (ra1 == wa3);
    assign byp2_hit  = write_enable && (wa3 != 5'd0) && (ra2 == wa3);
    assign byp1_data = byp1_hit ? wd3 : 32'd0;
    assign byp2_data = byp2_hit ? wd3 : 32'd0;
`endif

endmodule

// File: doc/wb_stage.md
WB_STAGE -- requirements
Module: wb_stage

Interface
REQ-001 SHALL have parameter LOAD_TIMEOUT, default 255: maximum cycles waited for a load response (1..255).
REQ-002 SHALL have ports, one per line:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- ex_valid  in  1  execute stage presents a result.
- ex_ready  out  1  wb_stage accepts the result this cycle.
- ex_rd  in  5  destination register.
- ex_data  in  32  ALU result; ignored for loads.
- ex_is_load  in  1  result arrives later on mem_rvalid/mem_rdata.
- mem_rvalid  in  1  load data valid.
- mem_rdata  in  32  load data.
- write_enable  out  1  register-file write strobe.
- wa3  out  5  register-file write address.
- wd3  out  32  register-file write data.
- busy  out  1  waiting for a load response.
- err  out  1  sticky protocol/timeout error.
- wb_count  out  16  count of register writes performed.

Function
REQ-003 SHALL implement FSM states IDLE and WAIT_LOAD.
REQ-004 SHALL drive ex_ready=1 only in IDLE; a transfer occurs when ex_valid && ex_ready.
REQ-005 SHALL, on a non-load transfer with ex_rd!=0, assert write_enable=1, wa3=ex_rd, wd3=ex_data in the next cycle, for exactly one cycle.
REQ-006 SHALL, on any transfer with ex_rd==0, perform no write; load handshake still completes.
REQ-007 SHALL, on a load transfer, latch ex_rd, clear the timeout counter and enter WAIT_LOAD next cycle.
REQ-008 SHALL ignore mem_rvalid in the transfer cycle itself; response latency is at least 1 cycle.
REQ-009 SHALL, in WAIT_LOAD with mem_rvalid=1, return to IDLE and drive write_enable=1, wa3=latched rd, wd3=mem_rdata next cycle (unless rd==0).
REQ-010 SHALL, in WAIT_LOAD, increment the counter each cycle without mem_rvalid; when it reaches LOAD_TIMEOUT, set err, return to IDLE, perform no write.
REQ-011 SHALL give mem_rvalid priority when it coincides with the timeout cycle.
REQ-012 SHALL set err when mem_rvalid=1 while in IDLE (outside REQ-008); such data SHALL be discarded.
REQ-013 SHALL drive busy=1 exactly while in WAIT_LOAD.
REQ-014 SHALL increment wb_count by 1 in each cycle write_enable=1, wrapping 0xFFFF->0x0000.
REQ-015 SHALL retire results strictly in acceptance order; at most one result in flight.
REQ-016 SHALL register write_enable, wa3, wd3; ex_ready SHALL be decoded from state only.

Reset
REQ-017 SHALL, when reset=1 at a rising edge, enter IDLE and clear write_enable, wa3, wd3, err, wb_count, timeout counter; reset SHALL override all other activity.
REQ-018 SHALL, when reset occurs in WAIT_LOAD, abandon the pending load without writing; mem_rvalid in the first IDLE cycle after reset SHALL set err.

Configuration
REQ-019 SHALL, with macro WB_STAGE_BYPASS_EN defined, add inputs ra1, ra2 (5 each) and outputs byp1_hit, byp2_hit (1 each), byp1_data, byp2_data (32 each).
REQ-020 SHALL, with WB_STAGE_BYPASS_EN defined, combinationally drive bypN_hit=write_enable && wa3!=0 && raN==wa3 and bypN_data=wd3 when hit, else 0.
REQ-021 SHALL, without WB_STAGE_BYPASS_EN, omit those ports and all compare logic.

Verification
REQ-022 ALU path: ex_valid=1, ex_rd=5, ex_data=0x1234_5678, ex_is_load=0 -> next cycle write_enable=1, wa3=5, wd3=0x1234_5678, wb_count=1.
REQ-023 Load path: load to rd=7, mem_rvalid=1 with 0xDEAD_BEEF 3 cycles later -> busy=1 for 3 cycles, ex_ready=0, then write wa3=7, wd3=0xDEAD_BEEF.
REQ-024 Timeout: LOAD_TIMEOUT=4, load accepted, no mem_rvalid -> err=1 after 4 WAIT_LOAD cycles, no write, ex_ready=1 next cycle.
REQ-025 x0 and stray response: ex_rd=0 ALU transfer -> write_enable stays 0; mem_rvalid in IDLE -> err=1.
REQ-026 Reset mid-load plus bypass: reset during WAIT_LOAD -> IDLE, no write; with bypass enabled, ra1=9 during write of wa3=9, wd3=0xA5A5_A5A5 -> byp1_hit=1, byp1_data=0xA5A5_A5A5.
